red_pitaya_asg_sweep: RTL and testbench

//  Frequency-sweep scheduler for one ASG channel. Steps the 64-bit phase increment {step_o,step_lo_o} from a start
//  to a stop value by a fixed increment every dwell period. Each update issues a one-cycle strobe, wired to the channel's

---
 rtl/red_pitaya_asg_sweep.sv | 207 ++++++++++++++++++++
 tb/tb_red_pitaya_asg_sweep.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_asg_sweep.sv
// Frequency-sweep scheduler for one ASG channel.
// Walks the 64-bit phase increment {step_o,step_lo_o} from a start value to a
// stop value in fixed increments, one update per dwell period, and pulses
// step_upd_o on every update so the channel latches the new step.
// Single, repeat and ping-pong sweeps are supported.
module red_pitaya_asg_sweep #(
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  logic          dac_clk_i,
    input  logic          dac_rstn_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [63:0]   cfg_start_i,
    input  logic [63:0]   cfg_stop_i,
    input  logic [63:0]   cfg_inc_i,
    input  logic [DW-1:0] cfg_dwell_i,
    input  logic [1:0]    cfg_mode_i,
    output logic [31:0]   step_o,
    output logic [31:0]   step_lo_o,
    output logic          step_upd_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] upd_cnt_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state, state_nx;

    logic [1:0]    rst_sync;
    logic          rst_n;

    logic [63:0]   sh_start, sh_stop, sh_inc;
    logic [DW-1:0] sh_dwell;
    logic [1:0]    sh_mode;
    logic          cap;

    logic [63:0]   step_q, step_nx;
    logic [63:0]   target_q, target_nx;
    logic          tgt_stop_q, tgt_stop_nx;
    logic          dir_up_q, dir_up_nx;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_nx;
    logic [CW-1:0] upd_cnt_q, upd_cnt_nx;
    logic          upd_q, upd_nx;

    // One step from cur toward tgt, clamped so the target is never overshot.
    // A zero increment jumps straight to the target.
    function automatic logic [63:0] step_toward(input logic [63:0] cur,
                                                input logic [63:0] tgt,
                                                input logic [63:0] inc,
                                                input logic        up);
        logic [64:0] s;
        logic [63:0] r;
        if (up) begin
            s = {1'b0, cur} + {1'b0, inc};
            r = (s[64] || (s[63:0] > tgt)) ? tgt : s[63:0];
        end else begin
            s = {1'b0, cur} - {1'b0, inc};
            r = (s[64] || (s[63:0] < tgt)) ? tgt : s[63:0];
        end
        if (inc == 64'd0)
            r = tgt;
        return r;
    endfunction

    // Update counter sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    // Dwell of 0 behaves like 1; the counter holds cycles-to-wait minus one.
    function automatic logic [DW-1:0] dwell_reload(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - DW'(1);
    endfunction

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // FSM state register.
    always_ff @(posedge dac_clk_i or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state plus next values of the sweep datapath; stop_i overrides everything.
    always_comb begin
        state_nx     = state;
        cap          = 1'b0;
        step_nx      = step_q;
        target_nx    = target_q;
        tgt_stop_nx  = tgt_stop_q;
        dir_up_nx    = dir_up_q;
        dwell_cnt_nx = dwell_cnt_q;
        upd_cnt_nx   = upd_cnt_q;
        upd_nx       = 1'b0;
        if (stop_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_nx   = LOAD;
                        cap        = 1'b1;
                        upd_cnt_nx = '0;
                    end
                end
                LOAD: begin
                    state_nx     = RUN;
                    step_nx      = sh_start;
                    upd_nx       = 1'b1;
                    upd_cnt_nx   = sat_inc(upd_cnt_q);
                    dwell_cnt_nx = dwell_reload(sh_dwell);
                    target_nx    = sh_stop;
                    tgt_stop_nx  = 1'b1;
                    dir_up_nx    = (sh_stop >= sh_start);
                end
                RUN: begin
                    if (dwell_cnt_q != '0) begin
                        dwell_cnt_nx = dwell_cnt_q - DW'(1);
                    end else begin
                        dwell_cnt_nx = dwell_reload(sh_dwell);
                        if (step_q != target_q) begin
                            step_nx    = step_toward(step_q, target_q, sh_inc, dir_up_q);
                            upd_nx     = 1'b1;
                            upd_cnt_nx = sat_inc(upd_cnt_q);
                        end else begin
                            case (sh_mode)
                                2'd1: begin
                                    step_nx    = sh_start;
                                    upd_nx     = 1'b1;
                                    upd_cnt_nx = sat_inc(upd_cnt_q);
                                end
                                2'd2: begin
                                    target_nx   = tgt_stop_q ? sh_start : sh_stop;
                                    tgt_stop_nx = ~tgt_stop_q;
                                    dir_up_nx   = ~dir_up_q;
                                    step_nx     = step_toward(step_q, tgt_stop_q ? sh_start : sh_stop,
                                                              sh_inc, ~dir_up_q);
                                    upd_nx      = 1'b1;
                                    upd_cnt_nx  = sat_inc(upd_cnt_q);
                                end
                                default: state_nx = DONE;
                            endcase
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Shadow configuration, captured only when a sweep is launched.
    always_ff @(posedge dac_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sh_start <= '0;
            sh_stop  <= '0;
            sh_inc   <= '0;
            sh_dwell <= '0;
            sh_mode  <= '0;
        end else if (cap) begin
            sh_start <= cfg_start_i;
            sh_stop  <= cfg_stop_i;
            sh_inc   <= cfg_inc_i;
            sh_dwell <= cfg_dwell_i;
            sh_mode  <= cfg_mode_i;
        end
    end

    // Sweep datapath registers.
    always_ff @(posedge dac_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            target_q    <= '0;
            tgt_stop_q  <= 1'b0;
            dir_up_q    <= 1'b0;
            dwell_cnt_q <= '0;
            upd_cnt_q   <= '0;
            upd_q       <= 1'b0;
        end else begin
            step_q      <= step_nx;
            target_q    <= target_nx;
            tgt_stop_q  <= tgt_stop_nx;
            dir_up_q    <= dir_up_nx;
            dwell_cnt_q <= dwell_cnt_nx;
            upd_cnt_q   <= upd_cnt_nx;
            upd_q       <= upd_nx;
        end
    end

    assign step_o     = step_q[63:32];
    assign step_lo_o  = step_q[31:0];
    assign step_upd_o = upd_q;
    assign upd_cnt_o  = upd_cnt_q;
    assign busy_o     = (state == LOAD) || (state == RUN);
    assign done_o     = (state == DONE);

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Testbench for red_pitaya_asg_sweep: expected strobes are queued as the
// stimulus issues each sweep; a monitor pops and compares every strobe.
module tb_red_pitaya_asg_sweep;

    logic        clk;
    logic        clk_en;
    logic        rstn;
    logic        start_i, stop_i;
    logic [63:0] cfg_start, cfg_stop, cfg_inc;
    logic [31:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [31:0] step_o, step_lo_o;
    logic        step_upd_o, busy_o, done_o;
    logic [31:0] upd_cnt_o;

    typedef struct {
        logic [63:0] step;
        int          gap;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   start_cyc = 0;

    red_pitaya_asg_sweep #(.DW(32), .CW(32)) dut (
        .dac_clk_i   (clk),
        .dac_rstn_i  (rstn),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .cfg_start_i (cfg_start),
        .cfg_stop_i  (cfg_stop),
        .cfg_inc_i   (cfg_inc),
        .cfg_dwell_i (cfg_dwell),
        .cfg_mode_i  (cfg_mode),
        .step_o      (step_o),
        .step_lo_o   (step_lo_o),
        .step_upd_o  (step_upd_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .upd_cnt_o   (upd_cnt_o)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic push(input logic [63:0] step, input int gap, input logic [31:0] cnt);
        exp_t e;
        e.step = step;
        e.gap  = gap;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe is matched against the head of the queue.
    always @(negedge clk) begin
        cyc++;
        if (rstn && step_upd_o) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_strobe actual=%h required=none", {step_o, step_lo_o});
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_step", {step_o, step_lo_o}, mon_e.step);
                chk("strobe_cnt", 64'(upd_cnt_o), 64'(mon_e.cnt));
                if (mon_e.gap < 0)
                    chk("first_latency", 64'(cyc - start_cyc), 64'd2);
                else
                    chk("strobe_gap", 64'(cyc - last_cyc), 64'(mon_e.gap));
            end
            last_cyc = cyc;
        end
    end

    task automatic run_sweep(input logic [63:0] s, input logic [63:0] e, input logic [63:0] inc,
                             input logic [31:0] dw, input logic [1:0] md);
        @(negedge clk); #1;
        cfg_start = s;
        cfg_stop  = e;
        cfg_inc   = inc;
        cfg_dwell = dw;
        cfg_mode  = md;
        start_i   = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start_i   = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'd1);
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            n++;
            if (done_o) break;
        end
        chk("done_latency", 64'(n), 64'(exp_lat));
        chk("done_busy", 64'(busy_o), 64'd0);
    endtask

    task automatic abort_now(input logic [63:0] held, input logic [31:0] cnt);
        stop_i = 1'b1;
        @(negedge clk); #1;
        stop_i = 1'b0;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_step", {step_o, step_lo_o}, held);
        chk("abort_cnt", 64'(upd_cnt_o), 64'(cnt));
        repeat (6) @(negedge clk);
    endtask

    initial begin
        clk_en = 1'b1;
        rstn = 1'b0;
        start_i = 1'b0;
        stop_i = 1'b0;
        cfg_start = '0;
        cfg_stop = '0;
        cfg_inc = '0;
        cfg_dwell = '0;
        cfg_mode = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_step", {step_o, step_lo_o}, 64'd0);
        chk("rst_upd", 64'(step_upd_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_cnt", 64'(upd_cnt_o), 64'd0);

        // single up sweep, dwell 10
        push(64'h100_00000000, -1, 1);
        push(64'h200_00000000, 10, 2);
        push(64'h300_00000000, 10, 3);
        push(64'h400_00000000, 10, 4);
        run_sweep(64'h100_00000000, 64'h400_00000000, 64'h100_00000000, 10, 2'd0);
        drain(100);
        wait_done(10);
        chk("single_cnt", 64'(upd_cnt_o), 64'd4);
        chk("single_held", {step_o, step_lo_o}, 64'h400_00000000);

        // clamp at stop, mode 3
        push(64'h000_00000000, -1, 1);
        push(64'h100_00000000, 3, 2);
        push(64'h200_00000000, 3, 3);
        push(64'h250_00000000, 3, 4);
        run_sweep(64'h0, 64'h250_00000000, 64'h100_00000000, 3, 2'd3);
        drain(60);
        wait_done(3);

        // 64-bit overflow clamps to stop
        push(64'hFFFFFFFF_00000000, -1, 1);
        push(64'hFFFFFFFF_FFFFFFFF, 2, 2);
        run_sweep(64'hFFFFFFFF_00000000, 64'hFFFFFFFF_FFFFFFFF, 64'h1_00000000, 2, 2'd0);
        drain(40);
        wait_done(2);

        // ping-pong starting downward, dwell 0
        push(64'h300_00000000, -1, 1);
        push(64'h200_00000000, 1, 2);
        push(64'h100_00000000, 1, 3);
        push(64'h200_00000000, 1, 4);
        push(64'h300_00000000, 1, 5);
        push(64'h200_00000000, 1, 6);
        push(64'h100_00000000, 1, 7);
        run_sweep(64'h300_00000000, 64'h100_00000000, 64'h100_00000000, 0, 2'd2);
        drain(40);
        chk("pp_busy", 64'(busy_o), 64'd1);
        abort_now(64'h100_00000000, 7);

        // repeat sweep, aborted mid-dwell
        push(64'h100_00000000, -1, 1);
        push(64'h200_00000000, 4, 2);
        push(64'h100_00000000, 4, 3);
        push(64'h200_00000000, 4, 4);
        run_sweep(64'h100_00000000, 64'h200_00000000, 64'h100_00000000, 4, 2'd1);
        drain(60);
        @(negedge clk); #1;
        abort_now(64'h200_00000000, 4);

        // start and stop together in IDLE: stays idle
        @(negedge clk); #1;
        cfg_start = 64'h999_00000000;
        start_i = 1'b1;
        stop_i = 1'b1;
        @(negedge clk); #1;
        start_i = 1'b0;
        stop_i = 1'b0;
        chk("ss_busy", 64'(busy_o), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("ss_cnt", 64'(upd_cnt_o), 64'd4);

        // lo word carries into hi word
        push(64'h1_00000000, -1, 1);
        push(64'h1_80000000, 2, 2);
        push(64'h2_00000000, 2, 3);
        push(64'h2_80000000, 2, 4);
        run_sweep(64'h1_00000000, 64'h2_80000000, 64'h0_80000000, 2, 2'd0);
        drain(40);
        wait_done(2);

        // config written during the sweep is ignored
        push(64'h10_00000000, -1, 1);
        push(64'h20_00000000, 5, 2);
        push(64'h30_00000000, 5, 3);
        run_sweep(64'h10_00000000, 64'h30_00000000, 64'h10_00000000, 5, 2'd0);
        cfg_start = 64'hABC_00000000;
        cfg_stop  = 64'h1_00000000;
        cfg_inc   = 64'h1;
        cfg_dwell = 32'd1;
        cfg_mode  = 2'd2;
        drain(60);
        wait_done(5);

        // async reset with clock stopped, mid-sweep
        push(64'h500_00000000, -1, 1);
        run_sweep(64'h500_00000000, 64'h900_00000000, 64'h100_00000000, 8, 2'd0);
        drain(20);
        clk_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_step", {step_o, step_lo_o}, 64'd0);
        chk("arst_upd", 64'(step_upd_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_cnt", 64'(upd_cnt_o), 64'd0);
        #5;
        rstn = 1'b1;
        clk_en = 1'b1;
        repeat (4) @(negedge clk);

        // zero increment jumps straight to stop
        push(64'h700_00000000, -1, 1);
        push(64'h123_00000000, 2, 2);
        run_sweep(64'h700_00000000, 64'h123_00000000, 64'h0, 2, 2'd0);
        drain(40);
        wait_done(2);
        chk("inc0_held", {step_o, step_lo_o}, 64'h123_00000000);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
